gate_sweep_checker: RTL and testbench
=====================================

Name: gate_sweep_checker

Overview:
- Synthesizable, parametrised exhaustive stimulus generator and checker for 2-operand bitwise logic gates.
- Drives two WIDTH-bit operands into an external gate DUT through every one of the 2^(2*WIDTH) combinations.
- Compares the DUT output against an internal reference for a runtime-selected operation, and reports error count, first failing vector and pass/fail.
- Replaces hand-written per-vector gate benches; instantiated alongside the gate under test in sim or on FPGA.

Parameters:
- WIDTH, 1, operand/result bit width (1..8).
- SETTLE, 1, cycles the operands are held before sampling dut_out (>=1).
- ERR_W, 16, error counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a sweep; honoured only in IDLE or DONE.
- abort  in  1  synchronous abort; forces IDLE.
- op_sel  in  3  operation, latched on accepted start: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR; 6 and 7 decode as AND.
- a_out  out  WIDTH  operand A to DUT (registered).
- b_out  out  WIDTH  operand B to DUT (registered).
- dut_out  in  WIDTH  DUT result.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; held until the next accepted start, abort or rst.
- pass  out  1  done && err_count==0.
- err_count  out  ERR_W  mismatching vectors; saturates at all-ones.
- fail_valid  out  1  at least one mismatch recorded.
- fail_a  out  WIDTH  A of the first mismatch.
- fail_b  out  WIDTH  B of the first mismatch.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; vector counter 0; latched op 0.
- State machine: IDLE, HOLD, CHECK, DONE.
- Vector counter vec is 2*WIDTH bits wide; a = vec[WIDTH-1:0], b = vec[2*WIDTH-1:WIDTH]. For WIDTH=1 the order is (0,0), (1,0), (0,1), (1,1).
- Accepted start edge (IDLE or DONE):
  - vec, a_out, b_out <= 0.
  - Latch op_sel.
  - Clear err_count, fail_*, done and pass.
  - busy <= 1; state <= HOLD.
- HOLD: stay SETTLE cycles (internal counter), then go to CHECK.
- CHECK (one cycle):
  - expected = op(a_out, b_out), computed bitwise across WIDTH.
  - A mismatch is any bit difference with dut_out; a mismatch counts one error per vector.
  - On mismatch, err_count increments, saturating at 2^ERR_W-1.
  - On the first mismatch only, capture fail_a/fail_b and set fail_valid.
  - If vec is all-ones: state DONE, busy <= 0, done <= 1, pass <= (no errors in the sweep).
  - Otherwise: vec increments; a_out/b_out load the new vec on the same edge; state HOLD.
- Timing: each vector takes SETTLE+1 cycles. done rises exactly 2^(2*WIDTH)*(SETTLE+1) clock edges after the accepted start edge.
- start while busy: ignored; no state change.
- start in DONE: restarts a sweep and clears the previous results.
- abort (any state, lower priority than rst):
  - Next edge: IDLE, busy=0, done=0, pass=0, a_out=b_out=0.
  - err_count and fail_* retain their values for debug.
- abort and start in the same cycle: abort wins.
- rst mid-sweep: immediate return to the reset values; no partial results survive.
- dut_out is sampled only in CHECK; X/changes in other states have no effect.

Test Plan:
- WIDTH=1, SETTLE=1, op=AND, correct AND DUT, start pulse -> a/b step (0,0), (1,0), (0,1), (1,1); done=1 at edge 8 after start; err_count=0; pass=1; fail_valid=0.
- WIDTH=1, op=AND, DUT wired as OR -> err_count=2; fail_valid=1; fail_a=1; fail_b=0; pass=0.
- WIDTH=4, SETTLE=2, op=XOR, DUT bit0 stuck-at-0 -> 256 vectors, done at edge 768; err_count=128; first fail a=1, b=0.
- WIDTH=4, ERR_W=4, op=NAND, DUT outputs constant 0 -> err_count saturates at 15 (not wrapping); pass=0.
- Abort at vector 2, then start again with op=OR against an OR DUT -> busy drops on the next edge; the new sweep starts from (0,0); pass=1; start pulses issued while busy change nothing.
- rst asserted mid-sweep (between edges) -> all outputs 0 immediately; after release the block stays in IDLE until start.

Source files
------------

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: exhaustive stimulus generator and checker for a 2-operand bitwise gate.
//
// The block walks a 2*WIDTH-bit vector counter through every operand pair and drives the pair
// to an external gate (a_out / b_out). Each pair is held for SETTLE cycles. On the following
// cycle dut_out is compared against a reference for the latched operation.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   start          begin a sweep (accepted only when idle or done)
//   abort          synchronous abort back to idle (results kept for debug)
//   op_sel         0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 AND
//   a_out, b_out   registered operands to the gate under test
//   dut_out        result from the gate under test
//   busy, done     sweep in progress / sweep complete (held)
//   pass           done with zero mismatches
//   err_count      saturating count of mismatching vectors
//   fail_valid     a mismatch has been recorded
//   fail_a, fail_b operands of the first mismatch
module gate_sweep_checker #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned ERR_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       op_sel,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);

  localparam int unsigned VecW  = 2 * WIDTH;
  localparam int unsigned HoldW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ErrMax   = '1;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StCheck,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [VecW-1:0]   vec_q, vec_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [2:0]        op_q, op_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              fail_valid_q, fail_valid_d;
  logic [WIDTH-1:0]  fail_a_q, fail_a_d;
  logic [WIDTH-1:0]  fail_b_q, fail_b_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  logic [WIDTH-1:0]  expected;
  logic              mismatch;

  // Operands come straight from the vector register, so a_out/b_out are flop outputs.
  assign a_out = vec_q[WIDTH-1:0];
  assign b_out = vec_q[VecW-1:WIDTH];

  // Reference result for the latched operation; unused codes fall back to AND.
  always_comb begin
    expected = a_out & b_out;
    case (op_q)
      3'd1:    expected = a_out | b_out;
      3'd2:    expected = a_out ^ b_out;
      3'd3:    expected = ~(a_out & b_out);
      3'd4:    expected = ~(a_out | b_out);
      3'd5:    expected = ~(a_out ^ b_out);
      default: expected = a_out & b_out;
    endcase
  end

  // Any differing bit makes the whole vector a single error.
  assign mismatch = |(expected ^ dut_out);

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    hold_d       = hold_q;
    op_d         = op_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_a_d     = fail_a_q;
    fail_b_d     = fail_b_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;

    if (abort) begin
      // Error count and first-failure capture survive an abort for debug.
      state_d = StIdle;
      vec_d   = '0;
      hold_d  = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d      = StHold;
            vec_d        = '0;
            hold_d       = '0;
            op_d         = op_sel;
            err_d        = '0;
            fail_valid_d = 1'b0;
            fail_a_d     = '0;
            fail_b_d     = '0;
            busy_d       = 1'b1;
            done_d       = 1'b0;
            pass_d       = 1'b0;
          end
        end

        StHold: begin
          if (hold_q == HoldLast) begin
            state_d = StCheck;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end

        StCheck: begin
          if (mismatch) begin
            if (err_q != ErrMax) begin
              err_d = err_q + 1'b1;
            end
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              fail_a_d     = a_out;
              fail_b_d     = b_out;
            end
          end
          if (&vec_q) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            // err_q does not yet include this vector, so fold in its result here.
            pass_d  = (err_q == '0) && !mismatch;
          end else begin
            state_d = StHold;
            vec_d   = vec_q + 1'b1;
            hold_d  = '0;
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      vec_q        <= '0;
      hold_q       <= '0;
      op_q         <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      hold_q       <= hold_d;
      op_q         <= op_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_a_q     <= fail_a_d;
      fail_b_q     <= fail_b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_a     = fail_a_q;
  assign fail_b     = fail_b_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: three checker instances (1-bit, 4-bit with SETTLE=2, 4-bit with
// a 4-bit error counter), each paired with a behavioural gate that can be mis-wired on purpose.
// Expected sweep results and operand sequences are queued when a sweep is started and popped
// as the checker produces them.
module tb_gate_sweep_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [2:0] op_sel;
  int         sel;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] err;
    logic [31:0] fv;
    logic [31:0] fa;
    logic [31:0] fb;
    logic [31:0] pass;
  } res_t;

  res_t exp_q[$];
  int   vec_q[$];

  always #5 clk = ~clk;

  function automatic logic [7:0] gate_fn(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      default: return a & b;
    endcase
  endfunction

  // Instance 0: WIDTH=1, SETTLE=1; its gate implements dut1_op.
  logic [2:0]  dut1_op;
  logic [0:0]  a1, b1, dut1, fa1, fb1;
  logic        busy1, done1, pass1, fv1;
  logic [15:0] err1;
  logic [7:0]  g1;

  // Instance 1: WIDTH=4, SETTLE=2; XOR gate with bit 0 stuck at 0.
  logic [3:0]  a4, b4, dut4, fa4, fb4;
  logic        busy4, done4, pass4, fv4;
  logic [15:0] err4;
  logic [7:0]  g4;

  // Instance 2: WIDTH=4, SETTLE=1, ERR_W=4; gate output tied to 0.
  logic [3:0]  as, bs, duts, fas, fbs;
  logic        busys, dones, passs, fvs;
  logic [3:0]  errs;

  always_comb begin
    g1   = gate_fn(dut1_op, {7'b0, a1}, {7'b0, b1});
    dut1 = g1[0:0];
    g4   = gate_fn(3'd2, {4'b0, a4}, {4'b0, b4});
    dut4 = g4[3:0] & 4'b1110;
    duts = 4'b0000;
  end

  gate_sweep_checker #(.WIDTH(1), .SETTLE(1), .ERR_W(16)) u_w1 (
    .clk(clk), .rst(rst), .start(start && sel == 0), .abort(abort && sel == 0),
    .op_sel(op_sel), .a_out(a1), .b_out(b1), .dut_out(dut1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1)
  );

  gate_sweep_checker #(.WIDTH(4), .SETTLE(2), .ERR_W(16)) u_w4 (
    .clk(clk), .rst(rst), .start(start && sel == 1), .abort(abort && sel == 1),
    .op_sel(op_sel), .a_out(a4), .b_out(b4), .dut_out(dut4), .busy(busy4), .done(done4),
    .pass(pass4), .err_count(err4), .fail_valid(fv4), .fail_a(fa4), .fail_b(fb4)
  );

  gate_sweep_checker #(.WIDTH(4), .SETTLE(1), .ERR_W(4)) u_sat (
    .clk(clk), .rst(rst), .start(start && sel == 2), .abort(abort && sel == 2),
    .op_sel(op_sel), .a_out(as), .b_out(bs), .dut_out(duts), .busy(busys), .done(dones),
    .pass(passs), .err_count(errs), .fail_valid(fvs), .fail_a(fas), .fail_b(fbs)
  );

  // Observation mux onto common 32-bit signals for the selected instance.
  logic [31:0] obs_a, obs_b, obs_busy, obs_done, obs_pass, obs_err, obs_fv, obs_fa, obs_fb;
  always_comb begin
    obs_a = '0; obs_b = '0; obs_busy = '0; obs_done = '0; obs_pass = '0;
    obs_err = '0; obs_fv = '0; obs_fa = '0; obs_fb = '0;
    case (sel)
      0: begin
        obs_a = 32'(a1); obs_b = 32'(b1); obs_busy = 32'(busy1); obs_done = 32'(done1);
        obs_pass = 32'(pass1); obs_err = 32'(err1); obs_fv = 32'(fv1);
        obs_fa = 32'(fa1); obs_fb = 32'(fb1);
      end
      1: begin
        obs_a = 32'(a4); obs_b = 32'(b4); obs_busy = 32'(busy4); obs_done = 32'(done4);
        obs_pass = 32'(pass4); obs_err = 32'(err4); obs_fv = 32'(fv4);
        obs_fa = 32'(fa4); obs_fb = 32'(fb4);
      end
      default: begin
        obs_a = 32'(as); obs_b = 32'(bs); obs_busy = 32'(busys); obs_done = 32'(dones);
        obs_pass = 32'(passs); obs_err = 32'(errs); obs_fv = 32'(fvs);
        obs_fa = 32'(fas); obs_fb = 32'(fbs);
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance k clock edges, landing 1 time unit after the last one.
  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input int err, input int fv, input int fa, input int fb, input int pass);
    res_t r;
    r.err = 32'(err); r.fv = 32'(fv); r.fa = 32'(fa); r.fb = 32'(fb); r.pass = 32'(pass);
    exp_q.push_back(r);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, obs_busy, 0);
    check({tag, "_done"}, obs_done, 0);
    check({tag, "_pass"}, obs_pass, 0);
    check({tag, "_a"}, obs_a, 0);
    check({tag, "_b"}, obs_b, 0);
  endtask

  // Full sweep on instance s: checks operand order, done latency and the queued result.
  task automatic sweep(input int s, input logic [2:0] op, input int w, input int settle,
                       input bit poke, input int mid_n, input int mid_err);
    int   per, nvec, n, ev;
    res_t r;
    per  = settle + 1;
    nvec = 1 << (2 * w);
    sel    = s;
    op_sel = op;
    vec_q.delete();
    for (int v = 0; v < nvec; v++) vec_q.push_back(v);
    start = 1'b1;
    step(1);
    start = 1'b0;
    n = 0;
    check("busy_at_start", obs_busy, 1);
    check("done_cleared", obs_done, 0);
    while (obs_done == 0 && n < nvec * per + 16) begin
      if (n % per == 0 && vec_q.size() > 0) begin
        ev = vec_q.pop_front();
        check("vec_a", obs_a, 32'(ev & ((1 << w) - 1)));
        check("vec_b", obs_b, 32'(ev >> w));
      end
      if (n == mid_n) check("mid_err", obs_err, 32'(mid_err));
      if (poke) start = (n == 3);
      step(1);
      n++;
    end
    start = 1'b0;
    check("done_edge", 32'(n), 32'(nvec * per));
    check("busy_end", obs_busy, 0);
    r = exp_q.pop_front();
    check("err_count", obs_err, r.err);
    check("fail_valid", obs_fv, r.fv);
    check("fail_a", obs_fa, r.fa);
    check("fail_b", obs_fb, r.fb);
    check("pass", obs_pass, r.pass);
    step(3);
    check("done_held", obs_done, 1);
    check("pass_held", obs_pass, r.pass);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; op_sel = 3'd0; sel = 0; dut1_op = 3'd0;
    step(3);
    check_idle_outputs("reset");
    check("reset_err", obs_err, 0);
    check("reset_fv", obs_fv, 0);
    rst = 1'b0;
    step(2);
    check("idle_after_reset", obs_busy, 0);

    // Correct AND gate: clean sweep.
    dut1_op = 3'd0;
    push_exp(0, 0, 0, 0, 1);
    sweep(0, 3'd0, 1, 1, 1'b0, -1, 0);

    // AND checked against an OR gate: mismatches at (1,0) and (0,1).
    dut1_op = 3'd1;
    push_exp(2, 1, 1, 0, 0);
    sweep(0, 3'd0, 1, 1, 1'b0, -1, 0);

    // NOR checked against an AND gate: mismatches at (0,0) and (1,1).
    dut1_op = 3'd0;
    push_exp(2, 1, 0, 0, 0);
    sweep(0, 3'd4, 1, 1, 1'b0, -1, 0);

    // op 6 decodes as AND; restart from done must clear the previous failure.
    push_exp(0, 0, 0, 0, 1);
    sweep(0, 3'd6, 1, 1, 1'b0, -1, 0);

    // XOR with bit 0 stuck at 0: every vector with a0^b0=1 fails.
    push_exp(128, 1, 1, 0, 0);
    sweep(1, 3'd2, 4, 2, 1'b0, -1, 0);

    // NAND against constant 0: all but (F,F) fail; counter must stick at 15.
    // After 40 checked vectors a wrapping counter would read 8.
    push_exp(15, 1, 0, 0, 0);
    sweep(2, 3'd3, 4, 1, 1'b0, 80, 15);

    // Abort at vector 2 with start asserted in the same cycle.
    sel = 0; dut1_op = 3'd1; op_sel = 3'd0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(4);
    check("pre_abort_a", obs_a, 0);
    check("pre_abort_b", obs_b, 1);
    check("pre_abort_err", obs_err, 1);
    abort = 1'b1; start = 1'b1;
    step(1);
    abort = 1'b0; start = 1'b0;
    check_idle_outputs("abort");
    check("abort_err_kept", obs_err, 1);
    check("abort_fv_kept", obs_fv, 1);
    check("abort_fa_kept", obs_fa, 1);
    check("abort_fb_kept", obs_fb, 0);
    step(2);
    check("abort_beats_start", obs_busy, 0);

    // Fresh OR sweep after abort, with a stray start pulse mid-sweep.
    push_exp(0, 0, 0, 0, 1);
    sweep(0, 3'd1, 1, 1, 1'b1, -1, 0);

    // Reset mid-sweep on the 4-bit instance after a few failures have accumulated.
    sel = 1; op_sel = 3'd2;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(20);
    check("pre_rst_err", obs_err, 3);
    check("pre_rst_fa", obs_fa, 1);
    #3;
    rst = 1'b1;
    #1;
    check_idle_outputs("mid_rst");
    check("mid_rst_err", obs_err, 0);
    check("mid_rst_fv", obs_fv, 0);
    check("mid_rst_fa", obs_fa, 0);
    step(1);
    rst = 1'b0;
    step(5);
    check_idle_outputs("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
